// File: rtl/fft_bit_reverse.sv
// rtl/fft_bit_reverse.sv - bit-reversed to natural order reorder buffer for FFT output
// Ping-pong frame store: one bank fills in bit-reversed order while the other drains in natural order.
module fft_bit_reverse #(
  parameter int N_LOG2 = 4,
  parameter int WIDTH  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in_r,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out_r,
  output logic [WIDTH-1:0] data_out_i,
  output logic             out_first,
  output logic             out_last
);

  localparam int N = 1 << N_LOG2;

  typedef enum logic {IDLE, READ} state_t;

  logic [2*WIDTH-1:0] mem_q [2][N];
  logic [N_LOG2-1:0]  wcnt_q;
  logic [N_LOG2-1:0]  rcnt_q;
  logic               wbank_q;
  logic               rbank_q;
  state_t             state_q;

  logic [N_LOG2-1:0]  wr_addr_d;
  logic               handoff_d;
  logic               rd_end_d;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) begin
      r[b] = a[N_LOG2-1-b];
    end
    return r;
  endfunction

  always_comb begin
    wr_addr_d = bitrev(wcnt_q);
    handoff_d = in_valid && (wcnt_q == {N_LOG2{1'b1}});
    rd_end_d  = (rcnt_q == {N_LOG2{1'b1}});
  end

  // Sample store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      mem_q[wbank_q][wr_addr_d] <= {data_in_r, data_in_i};
    end
  end

  // rcnt_q holds the index of the next entry to present, so entry 0 goes out on the hand-off edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      state_q    <= IDLE;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      if (in_valid) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (handoff_d) begin
        wbank_q                  <= ~wbank_q;
        rbank_q                  <= wbank_q;
        rcnt_q                   <= N_LOG2'(1);
        state_q                  <= READ;
        out_valid                <= 1'b1;
        out_first                <= 1'b1;
        out_last                 <= 1'b0;
        {data_out_r, data_out_i} <= mem_q[wbank_q][0];
      end else if (state_q == READ) begin
        rcnt_q                   <= rcnt_q + 1'b1;
        out_valid                <= 1'b1;
        out_first                <= 1'b0;
        out_last                 <= rd_end_d;
        {data_out_r, data_out_i} <= mem_q[rbank_q][rcnt_q];
        if (rd_end_d) begin
          state_q <= IDLE;
        end
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bit_reverse.sv
// tb/tb_fft_bit_reverse.sv - self-checking bench for fft_bit_reverse
module tb_fft_bit_reverse;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] data_in_r = '0;
  logic [11:0] data_in_i = '0;
  logic        out_valid;
  logic [11:0] data_out_r;
  logic [11:0] data_out_i;
  logic        out_first;
  logic        out_last;

  fft_bit_reverse #(.N_LOG2(4), .WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .out_valid(out_valid), .data_out_r(data_out_r), .data_out_i(data_out_i),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] in_r;
    logic [11:0] in_i;
    logic [11:0] exp_r;
    logic [11:0] exp_i;
  } vec_t;

  typedef struct {
    logic [11:0] r;
    logic [11:0] i;
    logic        f;
    logic        l;
    int          t;
  } cap_s;

  vec_t tbl [4][16];
  cap_s capq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) capq.push_back('{data_out_r, data_out_i, out_first, out_last, cyc});
  end

  function automatic int brev(input int k);
    return {28'd0, k[0], k[1], k[2], k[3]};
  endfunction

  // Natural-order sample k of test frame f.
  function automatic logic [11:0] nat(input int f, input int k, input bit im);
    logic [11:0] v;
    case (f)
      0:       v = 12'(k);
      1:       v = 12'(100 + k);
      2:       v = 12'(200 + k);
      default: v = k[0] ? 12'h800 : 12'h7FF;
    endcase
    if (f == 3 && im) v = k[1] ? 12'h7FF : 12'h800;
    else if (im)      v = -v;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int f, input int n, input bit gappy, output int tl);
    tl = 0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; gappy && g < 3 && $urandom_range(0, 1) == 1; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid  = 1'b1;
      data_in_r = tbl[f][k].in_r;
      data_in_i = tbl[f][k].in_i;
      tl = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_count(input int n, input int budget);
    int b = 0;
    while (capq.size() < n && b < budget) begin
      @(negedge clk);
      in_valid = 1'b0;
      b++;
    end
    idle(4);
    chk("burst_arrival", capq.size() >= n, 1);
  endtask

  task automatic check_burst(input int q0, input int f, input int t0);
    cap_s e;
    if (capq.size() < q0 + 16) begin
      chk("burst_len", capq.size() - q0, 16);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      e = capq[q0 + k];
      chk($sformatf("f%0d_re[%0d]", f, k), e.r, tbl[f][k].exp_r);
      chk($sformatf("f%0d_im[%0d]", f, k), e.i, tbl[f][k].exp_i);
      chk($sformatf("f%0d_first[%0d]", f, k), e.f, k == 0);
      chk($sformatf("f%0d_last[%0d]", f, k), e.l, k == 15);
      chk($sformatf("f%0d_cycle[%0d]", f, k), e.t, t0 + k);
    end
  endtask

  initial begin
    int q0, tl, tl1, tl2, seen;

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 16; k++) begin
        tbl[f][k].in_r  = nat(f, brev(k), 1'b0);
        tbl[f][k].in_i  = nat(f, brev(k), 1'b1);
        tbl[f][k].exp_r = nat(f, k, 1'b0);
        tbl[f][k].exp_i = nat(f, k, 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_data_r", data_out_r, 0);
    chk("rst_data_i", data_out_i, 0);

    // Single gapless frame
    q0 = capq.size();
    send(0, 16, 1'b0, tl);
    wait_count(q0 + 16, 40);
    check_burst(q0, 0, tl + 1);
    chk("single_len", capq.size() - q0, 16);

    // Three back-to-back frames
    q0 = capq.size();
    send(0, 16, 1'b0, tl);
    send(1, 16, 1'b0, tl1);
    send(2, 16, 1'b0, tl2);
    wait_count(q0 + 48, 60);
    check_burst(q0, 0, tl + 1);
    check_burst(q0 + 16, 1, tl1 + 1);
    check_burst(q0 + 32, 2, tl2 + 1);
    chk("triple_len", capq.size() - q0, 48);
    chk("triple_contig", tl2 + 1 - (tl + 1), 32);

    // Frame with random input gaps
    q0 = capq.size();
    send(0, 16, 1'b1, tl);
    wait_count(q0 + 16, 40);
    check_burst(q0, 0, tl + 1);
    chk("gappy_len", capq.size() - q0, 16);

    // Reset after a partial frame; in_valid during reset must be ignored
    q0 = capq.size();
    send(2, 9, 1'b0, tl);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    data_in_r = 12'h555;
    data_in_i = 12'h555;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(20);
    chk("partial_no_output", capq.size() - q0, 0);
    send(1, 16, 1'b0, tl);
    wait_count(q0 + 16, 40);
    check_burst(q0, 1, tl + 1);
    chk("post_rst_len", capq.size() - q0, 16);

    // Reset during the 5th output cycle
    q0 = capq.size();
    send(3, 16, 1'b0, tl);
    seen = 0;
    for (int b = 0; b < 40 && seen < 5; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_seen5", seen, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_first", out_first, 0);
    chk("abort_last", out_last, 0);
    chk("abort_data_r", data_out_r, 0);
    idle(20);
    chk("abort_len", capq.size() - q0, 5);
    q0 = capq.size();
    send(3, 16, 1'b0, tl);
    wait_count(q0 + 16, 40);
    check_burst(q0, 3, tl + 1);
    chk("extreme_len", capq.size() - q0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bit_reverse.md
FFT_BIT_REVERSE -- requirements
Module: fft_bit_reverse

Interface
REQ-001 The module SHALL have parameter N_LOG2, default 4, giving log2 of the FFT frame length N = 2^N_LOG2 (legal range 2..10).
REQ-002 The module SHALL have parameter WIDTH, default 12, giving the bit width of each real and imaginary sample.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: data_in_r/data_in_i carry one FFT output sample this cycle.
REQ-006 The module SHALL have port data_in_r, input, WIDTH bits: real part of the input sample, signed two's complement.
REQ-007 The module SHALL have port data_in_i, input, WIDTH bits: imaginary part of the input sample, signed two's complement.
REQ-008 The module SHALL have port out_valid, output, 1 bit: data_out_r/data_out_i hold a natural-order sample.
REQ-009 The module SHALL have port data_out_r, output, WIDTH bits: real part of the output sample.
REQ-010 The module SHALL have port data_out_i, output, WIDTH bits: imaginary part of the output sample.
REQ-011 The module SHALL have port out_first, output, 1 bit: qualifies the sample with natural index 0 of a frame.
REQ-012 The module SHALL have port out_last, output, 1 bit: qualifies the sample with natural index N-1 of a frame.

Function
REQ-013 The module SHALL sit downstream of the last FFT stage (Butterfly/Multiply chain), accept samples in bit-reversed order, and emit them in natural order.
REQ-014 The module SHALL hold two banks of N complex entries (ping-pong), each entry 2*WIDTH bits.
REQ-015 The module SHALL keep an N_LOG2-bit write counter wcnt that increments only on in_valid and wraps from N-1 to 0.
REQ-016 On in_valid, the module SHALL write the input sample to address bitrev(wcnt) of the current write bank, where bitrev reverses all N_LOG2 bits.
REQ-017 Input gaps (in_valid=0) SHALL be allowed anywhere; they pause wcnt and do not corrupt the frame.
REQ-018 On the edge that writes wcnt=N-1, the module SHALL toggle the write bank, hand the filled bank to the reader, and set the read counter rcnt to 0.
REQ-019 The reader SHALL have two states: IDLE and READ; the hand-off in REQ-018 moves it IDLE->READ or READ->READ (restart on the new bank); READ->IDLE occurs after the output with rcnt=N-1 when no new hand-off arrives on the same edge.
REQ-020 In READ, the module SHALL present bank entry rcnt on the registered outputs and increment rcnt each cycle, one sample per cycle with no backpressure.
REQ-021 Latency: out_valid SHALL rise on the first cycle after the edge that captured the last input sample of a frame, and SHALL stay high for exactly N consecutive cycles.
REQ-022 With gapless input, consecutive output frames SHALL be back-to-back: out_last of frame k and out_first of frame k+1 fall on adjacent cycles, with no idle cycle between them.
REQ-023 Because the output drains N samples in N cycles and refilling takes at least N cycles, the read bank SHALL never be overwritten before it has drained; no overflow flag exists.
REQ-024 out_first SHALL equal out_valid AND (rcnt==0), and out_last SHALL equal out_valid AND (rcnt==N-1), both aligned with their data.
REQ-025 When out_valid=0, data_out_r/data_out_i SHALL hold their last driven value; the verification bench checks them only when out_valid=1.
REQ-026 Sample values SHALL pass through bit-exact, with no rounding, saturation, or sign change.

Reset
REQ-027 When rst=1 at a clock edge, the module SHALL clear wcnt, rcnt, and the write-bank select to 0 and put the reader in IDLE.
REQ-028 When rst=1 at a clock edge, the module SHALL set out_valid, out_first, out_last, data_out_r and data_out_i to 0.
REQ-029 Buffer contents SHALL NOT be cleared by reset.
REQ-030 A reset during writing or reading SHALL discard the partial input frame and abort the output burst in the next cycle; the first complete frame after reset SHALL be output normally.
REQ-031 in_valid asserted in the same cycle as rst=1 SHALL be ignored.

Verification (N_LOG2=4, WIDTH=12)
REQ-032 Feed a single frame with data_in_r = bitrev(k) and data_in_i = -bitrev(k) for k=0..15 -> output is 0,1,...,15 (imag 0,-1,...,-15), out_valid high for 16 cycles starting 1 cycle after the last input, out_first on value 0, out_last on value 15.
REQ-033 Feed three gapless frames with distinct offsets 0, 100, 200 -> 48 contiguous out_valid cycles with correct natural order and out_first/out_last at cycles 0/15/16/31/32/47.
REQ-034 Feed one frame with random in_valid gaps (~50%) -> identical output to REQ-032, with start timed from the last accepted sample.
REQ-035 Assert rst for 1 cycle after 9 inputs, then send a full frame -> no output from the partial frame, then a correct 16-sample burst.
REQ-036 Assert rst in the 5th output cycle -> out_valid is 0 on the next cycle and stays 0 until a new full frame completes.
REQ-037 Feed extreme values 0x7FF and 0x800 in both components -> they are output bit-exact at their natural-order positions.
